// File: rtl/rs_nand.sv
// Bank of clocked cross-coupled-NAND RS latches with forbidden-state detection
// and policy-driven release-race resolution. Optional macro: RS_NAND_SYNC_EN.
module rs_nand #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned RACE_POLICY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Sn,
    input  logic [WIDTH-1:0] Rn,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] invalid,
    output logic [WIDTH-1:0] race_evt
);

    logic [WIDTH-1:0] sn_c, rn_c;

`ifdef RS_NAND_SYNC_EN
    // Two-flop synchronizers; reset to the inactive (high) level.
    logic [WIDTH-1:0] sn_s1, sn_s2, rn_s1, rn_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sn_s1 <= '1;
            sn_s2 <= '1;
            rn_s1 <= '1;
            rn_s2 <= '1;
        end else begin
            sn_s1 <= Sn;
            sn_s2 <= sn_s1;
            rn_s1 <= Rn;
            rn_s2 <= rn_s1;
        end
    end

    assign sn_c = sn_s2;
    assign rn_c = rn_s2;
`else
    assign sn_c = Sn;
    assign rn_c = Rn;
`endif

    logic [WIDTH-1:0] last_valid, in_forbid;
    logic [WIDTH-1:0] q_d, qn_d, lv_d, fb_d, re_d;

    always_comb begin
        q_d  = Q;
        qn_d = Qn;
        lv_d = last_valid;
        fb_d = in_forbid;
        re_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            unique case ({sn_c[i], rn_c[i]})
                2'b01: begin
                    q_d[i]  = 1'b1;
                    qn_d[i] = 1'b0;
                    lv_d[i] = 1'b1;
                    fb_d[i] = 1'b0;
                end
                2'b10: begin
                    q_d[i]  = 1'b0;
                    qn_d[i] = 1'b1;
                    lv_d[i] = 1'b0;
                    fb_d[i] = 1'b0;
                end
                2'b00: begin
                    q_d[i]  = 1'b1;
                    qn_d[i] = 1'b1;
                    fb_d[i] = 1'b1;
                end
                default: begin
                    if (in_forbid[i]) begin
                        // Direct release from forbidden: resolve the race deterministically.
                        if (RACE_POLICY == 1) begin
                            q_d[i] = 1'b0;
                        end else if (RACE_POLICY == 2) begin
                            q_d[i] = 1'b1;
                        end else begin
                            q_d[i] = last_valid[i];
                        end
                        qn_d[i] = ~q_d[i];
                        fb_d[i] = 1'b0;
                        re_d[i] = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Q          <= '0;
            Qn         <= '1;
            invalid    <= '0;
            race_evt   <= '0;
            last_valid <= '0;
            in_forbid  <= '0;
        end else begin
            Q          <= q_d;
            Qn         <= qn_d;
            invalid    <= q_d & qn_d;
            race_evt   <= re_d;
            last_valid <= lv_d;
            in_forbid  <= fb_d;
        end
    end

endmodule

// File: tb/tb_rs_nand.sv
// Self-checking bench for rs_nand: three 4-bit instances (race policies 0/1/2)
// driven in parallel, checked against a behavioural latch model.
module tb_rs_nand;

    localparam int W = 4;
`ifdef RS_NAND_SYNC_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sn    = '1;
    logic [W-1:0] rn    = '1;

    logic [W-1:0] q_w   [3];
    logic [W-1:0] qn_w  [3];
    logic [W-1:0] inv_w [3];
    logic [W-1:0] re_w  [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar p = 0; p < 3; p++) begin : g_dut
        rs_nand #(.WIDTH(W), .RACE_POLICY(p)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .Sn       (sn),
            .Rn       (rn),
            .Q        (q_w[p]),
            .Qn       (qn_w[p]),
            .invalid  (inv_w[p]),
            .race_evt (re_w[p])
        );
    end

    // Reference state, one entry per policy and per bit.
    bit m_q   [3][W];
    bit m_qn  [3][W];
    bit m_lv  [3][W];
    bit m_fb  [3][W];
    bit m_re  [3][W];
    logic [W-1:0] dly_sn [2];
    logic [W-1:0] dly_rn [2];

    task automatic model_edge();
        logic [W-1:0] es, er;
        if (!rst_n) begin
            for (int p = 0; p < 3; p++)
                for (int b = 0; b < W; b++) begin
                    m_q[p][b] = 0; m_qn[p][b] = 1; m_lv[p][b] = 0;
                    m_fb[p][b] = 0; m_re[p][b] = 0;
                end
            dly_sn[0] = '1; dly_sn[1] = '1;
            dly_rn[0] = '1; dly_rn[1] = '1;
            return;
        end
        es = (SYNC != 0) ? dly_sn[1] : sn;
        er = (SYNC != 0) ? dly_rn[1] : rn;
        dly_sn[1] = dly_sn[0]; dly_sn[0] = sn;
        dly_rn[1] = dly_rn[0]; dly_rn[0] = rn;
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < W; b++) begin
                m_re[p][b] = 0;
                if (!es[b] && !er[b]) begin
                    m_q[p][b] = 1; m_qn[p][b] = 1; m_fb[p][b] = 1;
                end else if (!es[b]) begin
                    m_q[p][b] = 1; m_qn[p][b] = 0; m_lv[p][b] = 1; m_fb[p][b] = 0;
                end else if (!er[b]) begin
                    m_q[p][b] = 0; m_qn[p][b] = 1; m_lv[p][b] = 0; m_fb[p][b] = 0;
                end else if (m_fb[p][b]) begin
                    case (p)
                        1:       m_q[p][b] = 0;
                        2:       m_q[p][b] = 1;
                        default: m_q[p][b] = m_lv[p][b];
                    endcase
                    m_qn[p][b] = !m_q[p][b];
                    m_fb[p][b] = 0;
                    m_re[p][b] = 1;
                end
            end
    endtask

    task automatic chk(input string tag, input int p, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s p%0d observed=%b expected=%b", tag, p, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [W-1:0] s, input logic [W-1:0] rr);
        logic [W-1:0] eq, eqn, einv, ere;
        rst_n = r; sn = s; rn = rr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < W; b++) begin
                eq[b]   = m_q[p][b];
                eqn[b]  = m_qn[p][b];
                einv[b] = m_q[p][b] & m_qn[p][b];
                ere[b]  = m_re[p][b];
            end
            chk("Q", p, q_w[p], eq);
            chk("Qn", p, qn_w[p], eqn);
            chk("invalid", p, inv_w[p], einv);
            chk("race_evt", p, re_w[p], ere);
        end
    endtask

    initial begin
        step(1'b0, '1, '1);
        step(1'b0, '1, '1);
        for (int p = 0; p < 3; p++) begin
            chk("rst_Q", p, q_w[p], 4'b0000);
            chk("rst_Qn", p, qn_w[p], 4'b1111);
            chk("rst_inv", p, inv_w[p], 4'b0000);
            chk("rst_race", p, re_w[p], 4'b0000);
        end
        // set, hold, reset, hold on bit 0
        step(1'b1, 4'b1110, 4'b1111);
        repeat (3) step(1'b1, 4'b1111, 4'b1111);
        step(1'b1, 4'b1111, 4'b1110);
        repeat (3) step(1'b1, 4'b1111, 4'b1111);
        // forbidden then direct release (race)
        step(1'b1, 4'b1110, 4'b1110);
        repeat (4) step(1'b1, 4'b1111, 4'b1111);
        // forbidden exited through plain reset / plain set
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b1, 4'b1111, 4'b0000);
        repeat (3) step(1'b1, 4'b1111, 4'b1111);
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b1, 4'b0000, 4'b1111);
        repeat (3) step(1'b1, 4'b1111, 4'b1111);
        // release race from Q=1 state
        step(1'b1, 4'b0000, 4'b0000);
        repeat (3) step(1'b1, 4'b1111, 4'b1111);
        // mixed per-bit pattern, then reset during forbidden
        step(1'b1, 4'b1110, 4'b1101);
        repeat (3) step(1'b1, 4'b1111, 4'b1111);
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        repeat (4) step(1'b1, 4'b1111, 4'b1111);
        // randomized traffic, biased toward holds so releases follow forbiddens
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] s, r;
            for (int b = 0; b < W; b++) begin
                int unsigned k;
                k = $urandom_range(0, 5);
                s[b] = (k == 0 || k == 1) ? 1'b0 : 1'b1;
                r[b] = (k == 0 || k == 2) ? 1'b0 : 1'b1;
            end
            step(($urandom_range(0, 39) != 0), s, r);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
